// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - NCH independent down-counting timers with one-shot or auto-reload modes.
module multi_timer #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CW-1:0]    load_ch,
    input  logic [WIDTH-1:0] cycles,
    input  logic             periodic,
    input  logic [NCH-1:0]   cancel,
    output logic [NCH-1:0]   busy,
    output logic [NCH-1:0]   expired,
    output logic             any_busy
);

    // Widen the index so the range check stays meaningful when NCH is not a power of two.
    logic [31:0] ch_idx;
    logic        load_ok;

    assign ch_idx  = 32'(load_ch);
    assign load_ok = load && (cycles != '0) && (ch_idx < 32'(NCH));

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] rld;
        logic             md;
        logic             exp_q;
        logic             hit;

        assign hit = load_ok && (ch_idx == 32'(i));

        // Priority: cancel, then load, then terminal count, then plain decrement.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt   <= '0;
                rld   <= '0;
                md    <= 1'b0;
                exp_q <= 1'b0;
            end else if (cancel[i]) begin
                cnt   <= '0;
                md    <= 1'b0;
                exp_q <= 1'b0;
            end else if (hit) begin
                cnt   <= cycles;
                rld   <= cycles;
                md    <= periodic;
                exp_q <= 1'b0;
            end else if (cnt == WIDTH'(1)) begin
                cnt   <= md ? rld : '0;
                exp_q <= 1'b1;
            end else if (cnt != '0) begin
                cnt   <= cnt - WIDTH'(1);
                exp_q <= 1'b0;
            end else begin
                exp_q <= 1'b0;
            end
        end

        assign busy[i]    = (cnt != '0);
        assign expired[i] = exp_q;
    end

    assign any_busy = |busy;

endmodule
